eggtimer_ctrl: RTL and testbench
================================

// Module: eggtimer_ctrl
// PURPOSE
//  Top-level mode controller for the egg timer. Consumes debounced button levels and the timer_en switch.
//  Drives the set-time counters with increment pulses, including hold-to-repeat.
//  Loads and runs the main countdown, and drives the mode and alarm LEDs.
//  Sits between the debouncers/dividers and the time counters and display mux.
// PARAMETERS
//  REPEAT_DELAY   2   pulse_300ms ticks a set button must be held before auto-repeat starts (>=1)
//  ALARM_SECONDS  10  pulse_1s ticks spent in DONE before auto-return to IDLE (>=1)
// PORTS
//  clk                in   1  5 MHz system clock
//  reset              in   1  asynchronous, active-low reset
//  pulse_300ms        in   1  1-cycle strobe every 300 ms (auto-repeat rate)
//  pulse_1s           in   1  1-cycle strobe every 1 s (alarm blink/timeout)
//  cooktime_req       in   1  debounced level, cook-time button
//  start_req          in   1  debounced level, start button
//  seconds_req        in   1  debounced level, seconds-set button
//  minutes_req        in   1  debounced level, minutes-set button
//  timer_en           in   1  raw slide switch, asynchronous
//  timer_done         in   1  main counter at 00:00
//  increment_seconds  out  1  1-cycle pulse, set-seconds counter +1
//  increment_minutes  out  1  1-cycle pulse, set-minutes counter +1
//  prog_mode          out  1  high in PROG; display shows set time
//  load_timer         out  1  1-cycle pulse, copy set time into main counter
//  main_timer_enable  out  1  high in RUN; countdown allowed
//  timer_enabled_led  out  1  synchronised timer_en
//  timer_on_led       out  1  high in RUN and PAUSE
//  alarm_led          out  1  blinks at 0.5 Hz in DONE
// BEHAVIOUR
//  - All outputs registered. On reset: state=IDLE, all outputs 0, repeat/alarm counters 0.
//  - timer_en passes through a 2-flop synchroniser: timer_enabled_led follows it 2-3 cycles later.
//  - Synced timer_en=0 forces state->IDLE next cycle from any state. This has top priority and kills in-flight pulses.
//  - Rising-edge detect (1-cycle) on cooktime_req, start_req, seconds_req, minutes_req.
//  - States: IDLE, PROG, LOAD, RUN, PAUSE, DONE.
//  - IDLE: cooktime edge -> PROG. start edge ignored.
//  - PROG: prog_mode=1.
//    - start edge -> LOAD.
//    - cooktime edge -> IDLE (cancel; set counters keep their values).
//  - LOAD: load_timer=1 for exactly one cycle, then -> RUN unconditionally. timer_done is ignored here.
//  - RUN: main_timer_enable=1.
//    - timer_done=1 -> DONE. This beats a same-cycle start edge.
//    - start edge -> PAUSE.
//    - cooktime edge -> PROG.
//  - PAUSE: main_timer_enable=0.
//    - start edge -> RUN.
//    - cooktime edge -> PROG.
//    - timer_done ignored.
//  - DONE: alarm_led toggles on each pulse_1s; alarm count +1 per pulse_1s.
//    - At count==ALARM_SECONDS -> IDLE.
//    - Any start or cooktime edge -> IDLE immediately.
//    - alarm_led=0 in every other state.
//  - Loading 00:00 is legal: LOAD->RUN, then DONE on the first RUN cycle seeing timer_done.
//  - Set buttons are only active in PROG; ignored in all other states.
//    - Rising edge -> one increment pulse on the next cycle.
//    - While held: repeat counter counts pulse_300ms. Once it reaches REPEAT_DELAY, one increment per further pulse_300ms.
//    - Release clears the repeat counter.
//    - seconds_req has priority: while it is held, minutes_req edges and repeats are ignored.
//    - Simultaneous edges -> seconds only.
//  - Leaving PROG clears repeat state. Re-entering PROG while a button is still held gives no pulse until release and re-press.
//  - Async reset mid-operation: immediate return to reset values; no load pulse is emitted.
// TESTING
//  1 Reset low 3 cycles, release -> all outputs 0, state IDLE; start press -> no load_timer.
//  2 timer_en=1, cooktime press -> prog_mode=1.
//    seconds press 1 cycle -> exactly 1 increment_seconds.
//    Hold through 5 pulse_300ms (REPEAT_DELAY=2) -> 1+3=4 pulses total.
//  3 In PROG, start press -> load_timer high exactly 1 cycle, then main_timer_enable=1, timer_on_led=1.
//  4 In RUN, start -> PAUSE (enable 0, timer_on_led 1); start -> RUN.
//    timer_done -> DONE: alarm toggles per pulse_1s, IDLE after 10 pulses.
//  5 In RUN, drop timer_en -> IDLE within 3 cycles; all mode outputs 0, timer_enabled_led=0.
//  6 Same-cycle seconds+minutes press in PROG -> increment_seconds only; same-cycle timer_done+start in RUN -> DONE.

Source files
------------

// File: rtl/eggtimer_ctrl.sv
// Egg timer mode controller: button edge detection, hold-to-repeat set pulses,
// IDLE/PROG/LOAD/RUN/PAUSE/DONE sequencing and LED drive.
module eggtimer_ctrl #(
  parameter int REPEAT_DELAY  = 2,
  parameter int ALARM_SECONDS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse_300ms,
  input  logic       pulse_1s,
  input  logic       cooktime_req,
  input  logic       start_req,
  input  logic       seconds_req,
  input  logic       minutes_req,
  input  logic       timer_en,
  input  logic       timer_done,
  output logic       increment_seconds,
  output logic       increment_minutes,
  output logic       prog_mode,
  output logic       load_timer,
  output logic       main_timer_enable,
  output logic       timer_enabled_led,
  output logic       timer_on_led,
  output logic       alarm_led,
  output logic [2:0] dbg_state
);

  localparam int RW = (REPEAT_DELAY  < 2) ? 1 : $clog2(REPEAT_DELAY + 1);
  localparam int AW = (ALARM_SECONDS < 2) ? 1 : $clog2(ALARM_SECONDS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PROG  = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic          r_en_meta;
  logic          r_en_sync;
  logic          r_ck_d;
  logic          r_st_d;
  logic          r_sc_d;
  logic          r_mn_d;
  logic          r_sec_arm;
  logic          r_min_arm;
  logic [RW-1:0] r_sec_cnt;
  logic [RW-1:0] r_min_cnt;
  logic [AW-1:0] r_alarm_cnt;
  logic          w_ck_edge;
  logic          w_st_edge;
  logic          w_sc_edge;
  logic          w_mn_edge;
  logic          w_alarm_last;
  logic          w_stay_prog;

  assign w_ck_edge    = cooktime_req & ~r_ck_d;
  assign w_st_edge    = start_req    & ~r_st_d;
  assign w_sc_edge    = seconds_req  & ~r_sc_d;
  assign w_mn_edge    = minutes_req  & ~r_mn_d;
  assign w_alarm_last = pulse_1s && (r_alarm_cnt == AW'(ALARM_SECONDS - 1));
  assign w_stay_prog  = (r_state == S_PROG) && (w_nxt == S_PROG);

  assign timer_enabled_led = r_en_sync;
  assign dbg_state         = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en_meta <= 1'b0;
      r_en_sync <= 1'b0;
      r_ck_d    <= 1'b0;
      r_st_d    <= 1'b0;
      r_sc_d    <= 1'b0;
      r_mn_d    <= 1'b0;
    end else begin
      r_en_meta <= timer_en;
      r_en_sync <= r_en_meta;
      r_ck_d    <= cooktime_req;
      r_st_d    <= start_req;
      r_sc_d    <= seconds_req;
      r_mn_d    <= minutes_req;
    end
  end

  // A low synchronised enable overrides every transition below.
  always_comb begin
    w_nxt = r_state;
    if (!r_en_sync) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_ck_edge) w_nxt = S_PROG;
        S_PROG:  begin
          if (w_st_edge)      w_nxt = S_LOAD;
          else if (w_ck_edge) w_nxt = S_IDLE;
        end
        S_LOAD:  w_nxt = S_RUN;
        S_RUN:   begin
          if (timer_done)     w_nxt = S_DONE;
          else if (w_st_edge) w_nxt = S_PAUSE;
          else if (w_ck_edge) w_nxt = S_PROG;
        end
        S_PAUSE: begin
          if (w_st_edge)      w_nxt = S_RUN;
          else if (w_ck_edge) w_nxt = S_PROG;
        end
        S_DONE:  begin
          if (w_st_edge || w_ck_edge) w_nxt = S_IDLE;
          else if (w_alarm_last)      w_nxt = S_IDLE;
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state           <= S_IDLE;
      r_alarm_cnt       <= '0;
      prog_mode         <= 1'b0;
      load_timer        <= 1'b0;
      main_timer_enable <= 1'b0;
      timer_on_led      <= 1'b0;
      alarm_led         <= 1'b0;
    end else begin
      r_state           <= w_nxt;
      prog_mode         <= (w_nxt == S_PROG);
      load_timer        <= (w_nxt == S_LOAD);
      main_timer_enable <= (w_nxt == S_RUN);
      timer_on_led      <= (w_nxt == S_RUN) || (w_nxt == S_PAUSE);
      if (w_nxt == S_DONE) begin
        if ((r_state == S_DONE) && pulse_1s) begin
          r_alarm_cnt <= r_alarm_cnt + AW'(1);
          alarm_led   <= ~alarm_led;
        end
      end else begin
        r_alarm_cnt <= '0;
        alarm_led   <= 1'b0;
      end
    end
  end

  // Repeat only follows a press that started inside PROG (arm flag), so a button
  // still held when PROG is re-entered stays silent until released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      increment_seconds <= 1'b0;
      increment_minutes <= 1'b0;
      r_sec_arm         <= 1'b0;
      r_min_arm         <= 1'b0;
      r_sec_cnt         <= '0;
      r_min_cnt         <= '0;
    end else begin
      increment_seconds <= 1'b0;
      increment_minutes <= 1'b0;
      if (!w_stay_prog) begin
        r_sec_arm <= 1'b0;
        r_min_arm <= 1'b0;
        r_sec_cnt <= '0;
        r_min_cnt <= '0;
      end else begin
        if (!seconds_req) begin
          r_sec_arm <= 1'b0;
          r_sec_cnt <= '0;
        end else if (w_sc_edge) begin
          increment_seconds <= 1'b1;
          r_sec_arm         <= 1'b1;
          r_sec_cnt         <= '0;
        end else if (r_sec_arm && pulse_300ms) begin
          if (r_sec_cnt == RW'(REPEAT_DELAY)) increment_seconds <= 1'b1;
          else                                r_sec_cnt <= r_sec_cnt + RW'(1);
        end

        if (!minutes_req) begin
          r_min_arm <= 1'b0;
          r_min_cnt <= '0;
        end else if (!seconds_req) begin
          if (w_mn_edge) begin
            increment_minutes <= 1'b1;
            r_min_arm         <= 1'b1;
            r_min_cnt         <= '0;
          end else if (r_min_arm && pulse_300ms) begin
            if (r_min_cnt == RW'(REPEAT_DELAY)) increment_minutes <= 1'b1;
            else                                r_min_cnt <= r_min_cnt + RW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_eggtimer_ctrl.sv
// Bench for eggtimer_ctrl: directed scenarios plus random stimulus, all checked
// cycle by cycle against a mode-level reference model through an expected queue.
module tb_eggtimer_ctrl;
  localparam int RD = 2;
  localparam int AS = 10;

  logic clk = 1'b0;
  logic rst_n, p300, p1s, ck, st, sc, mn, en, dn;
  logic increment_seconds, increment_minutes, prog_mode, load_timer;
  logic main_timer_enable, timer_enabled_led, timer_on_led, alarm_led;
  logic [2:0] dbg_state;

  int total = 0;
  int bad = 0;
  int cnt_isec = 0, cnt_imin = 0, cnt_load = 0, cnt_alarm = 0;
  logic prev_alarm = 1'b0;
  logic [7:0] exp_q[$];

  typedef enum int {M_IDLE, M_PROG, M_LOAD, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode;
  bit m_h1, m_h2, m_pck, m_pst, m_psc, m_pmn, m_slive, m_mlive;
  int m_sticks, m_mticks, m_alarm_n;

  eggtimer_ctrl #(.REPEAT_DELAY(RD), .ALARM_SECONDS(AS)) dut (
    .clk(clk), .reset(rst_n), .pulse_300ms(p300), .pulse_1s(p1s),
    .cooktime_req(ck), .start_req(st), .seconds_req(sc), .minutes_req(mn),
    .timer_en(en), .timer_done(dn),
    .increment_seconds(increment_seconds), .increment_minutes(increment_minutes),
    .prog_mode(prog_mode), .load_timer(load_timer), .main_timer_enable(main_timer_enable),
    .timer_enabled_led(timer_enabled_led), .timer_on_led(timer_on_led),
    .alarm_led(alarm_led), .dbg_state(dbg_state)
  );

  // clock: 5 MHz
  always #100 clk = ~clk;

  function automatic logic [7:0] dut_vec();
    return {increment_seconds, increment_minutes, prog_mode, load_timer,
            main_timer_enable, timer_enabled_led, timer_on_led, alarm_led};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: advances one clock with the inputs currently applied and
  // queues the outputs expected after the coming rising edge.
  task automatic model_push();
    bit en_now, e_ck, e_st, e_sc, e_mn, stay, is, im;
    mode_t old_m, new_m;
    logic [7:0] v;
    if (!rst_n) begin
      m_mode = M_IDLE; m_h1 = 0; m_h2 = 0;
      m_pck = 0; m_pst = 0; m_psc = 0; m_pmn = 0;
      m_slive = 0; m_mlive = 0; m_sticks = 0; m_mticks = 0; m_alarm_n = 0;
      exp_q.push_back(8'h00);
      return;
    end
    en_now = m_h2;
    e_ck = ck && !m_pck;
    e_st = st && !m_pst;
    e_sc = sc && !m_psc;
    e_mn = mn && !m_pmn;
    old_m = m_mode;
    new_m = old_m;
    if (!en_now) new_m = M_IDLE;
    else begin
      case (old_m)
        M_IDLE:  if (e_ck) new_m = M_PROG;
        M_PROG:  if (e_st) new_m = M_LOAD; else if (e_ck) new_m = M_IDLE;
        M_LOAD:  new_m = M_RUN;
        M_RUN:   if (dn) new_m = M_DONE; else if (e_st) new_m = M_PAUSE; else if (e_ck) new_m = M_PROG;
        M_PAUSE: if (e_st) new_m = M_RUN; else if (e_ck) new_m = M_PROG;
        M_DONE: begin
          if (e_st || e_ck) new_m = M_IDLE;
          else if (p1s) begin
            m_alarm_n++;
            if (m_alarm_n == AS) new_m = M_IDLE;
          end
        end
        default: new_m = M_IDLE;
      endcase
    end
    if (new_m != M_DONE) m_alarm_n = 0;

    is = 0; im = 0;
    stay = (old_m == M_PROG) && (new_m == M_PROG);
    if (!stay) begin
      m_slive = 0; m_mlive = 0; m_sticks = 0; m_mticks = 0;
    end else begin
      if (!sc) begin m_slive = 0; m_sticks = 0; end
      else if (e_sc) begin is = 1; m_slive = 1; m_sticks = 0; end
      else if (m_slive && p300) begin m_sticks++; if (m_sticks > RD) is = 1; end
      if (!mn) begin m_mlive = 0; m_mticks = 0; end
      else if (!sc) begin
        if (e_mn) begin im = 1; m_mlive = 1; m_mticks = 0; end
        else if (m_mlive && p300) begin m_mticks++; if (m_mticks > RD) im = 1; end
      end
    end

    v = {is, im, new_m == M_PROG, new_m == M_LOAD, new_m == M_RUN, m_h1,
         (new_m == M_RUN) || (new_m == M_PAUSE),
         (new_m == M_DONE) && (m_alarm_n % 2 == 1)};
    exp_q.push_back(v);
    m_h2 = m_h1; m_h1 = en;
    m_pck = ck; m_pst = st; m_psc = sc; m_pmn = mn;
    m_mode = new_m;
  endtask

  task automatic tick();
    model_push();
    @(negedge clk);
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin : pop_blk
      logic [7:0] e;
      e = exp_q.pop_front();
      chk("outputs", dut_vec(), e);
    end
    if (increment_seconds) cnt_isec++;
    if (increment_minutes) cnt_imin++;
    if (load_timer) cnt_load++;
    if (alarm_led != prev_alarm) cnt_alarm++;
    prev_alarm = alarm_led;
  end

  initial begin
    rst_n = 0; en = 1; p300 = 0; p1s = 0; ck = 0; st = 0; sc = 0; mn = 0; dn = 0;
    repeat (3) tick();
    rst_n = 1;
    chk("reset_state", dut_vec(), 8'h00);
    repeat (4) tick();
    st = 1; tick(); st = 0; tick(); tick();
    chk("idle_start_no_load", cnt_load, 0);
    chk("idle_no_prog", prog_mode, 0);

    ck = 1; tick(); ck = 0; tick();
    chk("enter_prog", prog_mode, 1);
    cnt_isec = 0; sc = 1; tick(); sc = 0; repeat (3) tick();
    chk("single_press", cnt_isec, 1);
    cnt_isec = 0; sc = 1; tick();
    repeat (5) begin tick(); tick(); p300 = 1; tick(); p300 = 0; end
    sc = 0; repeat (2) tick();
    chk("hold_repeat", cnt_isec, 4);

    cnt_load = 0; st = 1; tick(); st = 0; repeat (3) tick();
    chk("load_once", cnt_load, 1);
    chk("run_enable", main_timer_enable, 1);
    chk("run_on_led", timer_on_led, 1);
    chk("run_prog_off", prog_mode, 0);
    st = 1; tick(); st = 0; tick();
    chk("pause_enable", main_timer_enable, 0);
    chk("pause_on_led", timer_on_led, 1);
    st = 1; tick(); st = 0; tick();
    chk("resume_enable", main_timer_enable, 1);

    cnt_alarm = 0; dn = 1; tick(); dn = 0; tick();
    chk("done_enable", main_timer_enable, 0);
    chk("done_on_led", timer_on_led, 0);
    repeat (9) begin p1s = 1; tick(); p1s = 0; tick(); end
    chk("alarm_after9", alarm_led, 1);
    p1s = 1; tick(); p1s = 0; tick();
    chk("alarm_toggles", cnt_alarm, 10);
    chk("alarm_off", alarm_led, 0);
    ck = 1; tick(); ck = 0; tick();
    chk("idle_after_alarm", prog_mode, 1);

    st = 1; tick(); st = 0; repeat (3) tick();
    chk("run_again", main_timer_enable, 1);
    en = 0; repeat (3) tick();
    chk("en_off_enable", main_timer_enable, 0);
    chk("en_off_led", timer_enabled_led, 0);
    chk("en_off_on_led", timer_on_led, 0);
    en = 1; repeat (4) tick();

    ck = 1; tick(); ck = 0; tick();
    cnt_isec = 0; cnt_imin = 0; sc = 1; mn = 1; tick(); repeat (3) tick();
    chk("simul_sec", cnt_isec, 1);
    chk("simul_min", cnt_imin, 0);
    sc = 0; mn = 0; tick();
    mn = 1; tick(); mn = 0; tick(); tick();
    chk("min_press", cnt_imin, 1);

    st = 1; tick(); st = 0; repeat (3) tick();
    dn = 1; st = 1; tick(); dn = 0; st = 0; tick();
    chk("done_beats_start", timer_on_led, 0);
    p1s = 1; tick(); p1s = 0; tick();
    chk("done_alarm_on", alarm_led, 1);
    ck = 1; tick(); ck = 0; tick();
    chk("done_cancel", alarm_led, 0);

    ck = 1; tick(); ck = 0; tick();
    st = 1; tick();
    chk("load_seen", load_timer, 1);
    st = 0; rst_n = 0; #1;
    chk("async_reset_load", load_timer, 0);
    tick(); tick();
    rst_n = 1; cnt_load = 0; repeat (4) tick();
    chk("no_load_after_reset", cnt_load, 0);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 5) == 0) ck = ~ck;
      if ($urandom_range(0, 7) == 0) st = ~st;
      if ($urandom_range(0, 4) == 0) sc = ~sc;
      if ($urandom_range(0, 4) == 0) mn = ~mn;
      p300 = ($urandom_range(0, 4) == 0);
      p1s  = ($urandom_range(0, 5) == 0);
      dn   = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 399) == 0) en = ~en;
      rst_n = (c < 2000 || c >= 2002);
      tick();
    end
    ck = 0; st = 0; sc = 0; mn = 0; p300 = 0; p1s = 0; dn = 0; rst_n = 1;
    repeat (3) tick();
    @(posedge clk); #5;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
